ct_mat_iss_sched: RTL and testbench
===================================

# ct_mat_iss_sched

Matrix issue scheduler. Accepts up to three decoded matrix instructions per cycle from the IDU decode slots (type/data from the per-slot matrix decoders), buffers them in program order in a small circular queue, and issues them one per cycle to the matrix execution unit over a valid/ready handshake. It serializes matrix configuration instructions: no further issue occurs until the execution unit signals that the configuration has completed. It sits between the matrix IDU decode stage and the matrix execution front end.

## Interface
Parameters:
- DEPTH, 8, queue entries; power of two, ≥4
- CFG_TYPE, 4'h1, mat_type value that marks a serializing configuration instruction

Ports (cpuclk single clock; cpurst_b asynchronous, active-low):
- cpuclk  in  1  clock
- cpurst_b  in  1  async active-low reset
- rtu_yy_xx_flush  in  1  pipeline flush
- id_inst{0,1,2}_mat_vld  in  1  slot holds a matrix instruction
- id_inst{0,1,2}_mat_type  in  4  decoded matrix type
- id_inst{0,1,2}_mat_data  in  37  decoded matrix payload
- mat_sched_id_stall  out  1  IDU must hold all three slots this cycle
- mat_sched_iss_vld  out  1  issue valid
- mat_sched_iss_type  out  4  issued type
- mat_sched_iss_data  out  37  issued payload
- mat_exu_sched_rdy  in  1  execution unit accepts issue
- mat_exu_sched_cfg_done  in  1  single-cycle pulse: configuration complete
- mat_sched_empty  out  1  queue empty and FSM in RUN

## Operation
- Queue: DEPTH entries of {type[3:0], data[36:0]}; rd_ptr/wr_ptr are log2(DEPTH)+1 bits wide (the MSB is the wrap bit); count = wr_ptr − rd_ptr; full when count == DEPTH.
- Enqueue: nv = number of asserted slot valids (0–3). stall = flush | (nv > DEPTH − count_q), where count_q is the registered count. Freed space from a same-cycle dequeue is not counted.
- When not stalled, all valid slots enqueue in the same cycle in order slot0, slot1, slot2. Invalid slots are skipped (compacted), so a valid slot2 with an invalid slot1 lands directly after slot0. wr_ptr advances by nv.
- Stall is all-or-none: a partial enqueue never occurs.
- Issue: iss_vld/type/data come combinationally from the head entry. A dequeue happens on iss_vld & rdy, and rd_ptr advances by 1.
- FSM states: RUN, CFG_WAIT.
  - RUN: iss_vld = !empty. A dequeue whose type == CFG_TYPE moves the FSM to CFG_WAIT.
  - CFG_WAIT: iss_vld = 0. cfg_done moves the FSM to RUN. Enqueue continues normally in this state.
  - cfg_done asserted while in RUN is ignored.
- Flush: the cycle flush is asserted, stall = 1, no enqueue, no dequeue (iss_vld forced 0). Next cycle: pointers are 0, FSM is RUN, and the queue is empty. Flush overrides a same-cycle cfg_done.
- Reset: pointers = 0, FSM = RUN. Outputs after reset: iss_vld 0, stall 0, empty 1. iss_type/data are don't-care while iss_vld = 0. Entries are not reset.

## Timing
- An instruction enqueued at cycle N is visible on the issue port at N+1 at the earliest.
- Sustained throughput is 1 issue per cycle. Back-to-back issue is allowed with rdy held high.
- A CFG_TYPE issue at cycle N: CFG_WAIT from N+1. If cfg_done arrives at cycle M, the next issue is possible at M+1.
- stall is combinational from the slot valids and registered state. It has no dependence on rdy or cfg_done.
- Once iss_vld is asserted it is held with stable payload until rdy, unless a flush occurs.

## Structure
- Shared package ct_mat_pkg: MAT_TYPE_W = 4, MAT_DATA_W = 37, the mat_type encoding constants (including CFG_TYPE), and a typedef mat_inst_t = {type, data}. The decoder and this scheduler share it.
- One sub-module, ct_mat_iss_compact: a purely combinational unit. It maps the 3 slot valids to per-slot write offsets (0–2) and produces nv.
- Storage, pointers and FSM live in the top module.

## Test plan
- Reset, then slots {v,v,v} with types 2,3,4 and rdy = 1 → no stall; issue at cycles 1, 2, 3 in order with types 2, 3, 4; empty at cycle 4.
- Slot0 and slot2 valid, slot1 invalid, data 0xA and 0xC → issue order A then C with no gap.
- rdy = 0, fill to count = 6 with DEPTH = 8, then offer 3 valids → stall = 1 and count stays at 6; offer 2 valids → accepted and count = 8; full.
- Issue CFG_TYPE, then a type-2 instruction queued behind it, cfg_done 5 cycles later → iss_vld stays 0 for those 5 cycles; type-2 issues the cycle after cfg_done.
- Queue holds 4 entries in CFG_WAIT; assert flush together with cfg_done and 3 valids → stall = 1 that cycle; next cycle empty = 1, FSM in RUN, nothing issued.
- Deassert cpurst_b asynchronously mid-stream → iss_vld drops to 0 immediately and empty = 1; after release, a fresh enqueue issues normally.

Source files
------------

// File: rtl/ct_mat_pkg.sv
// Shared matrix-instruction definitions used by the matrix decoders and the issue scheduler.
package ct_mat_pkg;
   localparam int MAT_TYPE_W = 4;
   localparam int MAT_DATA_W = 37;

   localparam logic [MAT_TYPE_W-1:0] MAT_TYPE_NOP = 4'h0;
   localparam logic [MAT_TYPE_W-1:0] MAT_TYPE_CFG = 4'h1;
   localparam logic [MAT_TYPE_W-1:0] MAT_TYPE_LD  = 4'h2;
   localparam logic [MAT_TYPE_W-1:0] MAT_TYPE_ST  = 4'h3;
   localparam logic [MAT_TYPE_W-1:0] MAT_TYPE_MMA = 4'h4;
   localparam logic [MAT_TYPE_W-1:0] CFG_TYPE     = MAT_TYPE_CFG;

   typedef struct packed {
      logic [MAT_TYPE_W-1:0] mat_type;
      logic [MAT_DATA_W-1:0] data;
   } mat_inst_t;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_CFG_WAIT = 1'b1
   } sched_state_t;
endpackage

// File: rtl/ct_mat_iss_compact.sv
// Maps the three decode-slot valids to compacted queue write offsets and the enqueue count.
module ct_mat_iss_compact (
   input  logic [2:0] i_slot_vld,
   output logic [1:0] o_off0,
   output logic [1:0] o_off1,
   output logic [1:0] o_off2,
   output logic [1:0] o_nv
);
   logic [1:0] w_v0;
   logic [1:0] w_v1;
   logic [1:0] w_v2;

   assign w_v0   = {1'b0, i_slot_vld[0]};
   assign w_v1   = {1'b0, i_slot_vld[1]};
   assign w_v2   = {1'b0, i_slot_vld[2]};

   assign o_off0 = 2'd0;
   assign o_off1 = w_v0;
   assign o_off2 = w_v0 + w_v1;
   assign o_nv   = w_v0 + w_v1 + w_v2;
endmodule

// File: rtl/ct_mat_iss_sched.sv
// Matrix issue scheduler: in-order circular queue fed by three decode slots, single issue
// per cycle, with a serializing wait after every configuration instruction.
//
//   state       | meaning
//   ST_RUN      | head of queue may issue whenever the queue is non-empty
//   ST_CFG_WAIT | a config instruction issued; hold issue until cfg_done
module ct_mat_iss_sched #(
   parameter int                                 DEPTH    = 8,
   parameter logic [ct_mat_pkg::MAT_TYPE_W-1:0]  CFG_TYPE = ct_mat_pkg::MAT_TYPE_CFG
) (
   input  logic                               cpuclk,
   input  logic                               cpurst_b,
   input  logic                               rtu_yy_xx_flush,
   input  logic                               id_inst0_mat_vld,
   input  logic [ct_mat_pkg::MAT_TYPE_W-1:0]  id_inst0_mat_type,
   input  logic [ct_mat_pkg::MAT_DATA_W-1:0]  id_inst0_mat_data,
   input  logic                               id_inst1_mat_vld,
   input  logic [ct_mat_pkg::MAT_TYPE_W-1:0]  id_inst1_mat_type,
   input  logic [ct_mat_pkg::MAT_DATA_W-1:0]  id_inst1_mat_data,
   input  logic                               id_inst2_mat_vld,
   input  logic [ct_mat_pkg::MAT_TYPE_W-1:0]  id_inst2_mat_type,
   input  logic [ct_mat_pkg::MAT_DATA_W-1:0]  id_inst2_mat_data,
   output logic                               mat_sched_id_stall,
   output logic                               mat_sched_iss_vld,
   output logic [ct_mat_pkg::MAT_TYPE_W-1:0]  mat_sched_iss_type,
   output logic [ct_mat_pkg::MAT_DATA_W-1:0]  mat_sched_iss_data,
   input  logic                               mat_exu_sched_rdy,
   input  logic                               mat_exu_sched_cfg_done,
   output logic                               mat_sched_empty
);
   import ct_mat_pkg::*;

   localparam int          PW      = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_L = (PW+1)'(DEPTH);

   logic [PW:0]   r_rd_ptr;
   logic [PW:0]   r_wr_ptr;
   mat_inst_t     r_mem [DEPTH];
   sched_state_t  r_state;
   sched_state_t  w_state_nxt;

   logic [PW:0]   w_count;
   logic [PW:0]   w_space;
   logic          w_empty;
   logic [2:0]    w_slot_vld;
   mat_inst_t     w_slot [3];
   logic [1:0]    w_off [3];
   logic [1:0]    w_nv;
   logic [PW-1:0] w_wr_idx [3];
   logic          w_stall;
   logic          w_iss_vld;
   logic          w_deq;
   mat_inst_t     w_head;

   assign w_slot_vld = {id_inst2_mat_vld, id_inst1_mat_vld, id_inst0_mat_vld};
   assign w_slot[0]  = {id_inst0_mat_type, id_inst0_mat_data};
   assign w_slot[1]  = {id_inst1_mat_type, id_inst1_mat_data};
   assign w_slot[2]  = {id_inst2_mat_type, id_inst2_mat_data};

   ct_mat_iss_compact u_compact (
      .i_slot_vld (w_slot_vld),
      .o_off0     (w_off[0]),
      .o_off1     (w_off[1]),
      .o_off2     (w_off[2]),
      .o_nv       (w_nv)
   );

   assign w_count = r_wr_ptr - r_rd_ptr;
   assign w_space = DEPTH_L - w_count;
   assign w_empty = (w_count == '0);

   // Space is judged on the registered count only, so stall never depends on rdy.
   assign w_stall = rtu_yy_xx_flush | ((PW+1)'(w_nv) > w_space);

   always_comb begin
      for (int s = 0; s < 3; s++) begin
         w_wr_idx[s] = r_wr_ptr[PW-1:0] + PW'(w_off[s]);
      end
   end

   assign w_head    = r_mem[r_rd_ptr[PW-1:0]];
   assign w_iss_vld = (r_state == ST_RUN) & ~w_empty & ~rtu_yy_xx_flush;
   assign w_deq     = w_iss_vld & mat_exu_sched_rdy;

   always_comb begin
      w_state_nxt = r_state;
      if (rtu_yy_xx_flush) begin
         w_state_nxt = ST_RUN;
      end else begin
         case (r_state)
            ST_RUN:      if (w_deq && (w_head.mat_type == CFG_TYPE)) w_state_nxt = ST_CFG_WAIT;
            ST_CFG_WAIT: if (mat_exu_sched_cfg_done) w_state_nxt = ST_RUN;
            default:     w_state_nxt = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
      end else if (rtu_yy_xx_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
      end else begin
         if (!w_stall) r_wr_ptr <= r_wr_ptr + (PW+1)'(w_nv);
         if (w_deq)    r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
      end
   end

   // Queue payload is not reset; only the pointers define what is live.
   always_ff @(posedge cpuclk) begin
      for (int s = 0; s < 3; s++) begin
         if (!w_stall && w_slot_vld[s]) r_mem[w_wr_idx[s]] <= w_slot[s];
      end
   end

   assign mat_sched_id_stall = w_stall;
   assign mat_sched_iss_vld  = w_iss_vld;
   assign mat_sched_iss_type = w_head.mat_type;
   assign mat_sched_iss_data = w_head.data;
   assign mat_sched_empty    = w_empty & (r_state == ST_RUN);
endmodule

// File: tb/tb_ct_mat_iss_sched.sv
// Bench for ct_mat_iss_sched: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_ct_mat_iss_sched;
   localparam int DEPTH = 8;
   localparam logic [3:0] CFG = 4'h1;

   logic        cpuclk = 1'b0;
   logic        cpurst_b;
   logic        flush;
   logic        v0, v1, v2;
   logic [3:0]  t0, t1, t2;
   logic [36:0] d0, d1, d2;
   logic        rdy, cfg_done;
   logic        stall, iss_vld, empty;
   logic [3:0]  iss_type;
   logic [36:0] iss_data;

   always #5 cpuclk = ~cpuclk;

   ct_mat_iss_sched #(.DEPTH(DEPTH), .CFG_TYPE(CFG)) dut (
      .cpuclk                 (cpuclk),
      .cpurst_b               (cpurst_b),
      .rtu_yy_xx_flush        (flush),
      .id_inst0_mat_vld       (v0),
      .id_inst0_mat_type      (t0),
      .id_inst0_mat_data      (d0),
      .id_inst1_mat_vld       (v1),
      .id_inst1_mat_type      (t1),
      .id_inst1_mat_data      (d1),
      .id_inst2_mat_vld       (v2),
      .id_inst2_mat_type      (t2),
      .id_inst2_mat_data      (d2),
      .mat_sched_id_stall     (stall),
      .mat_sched_iss_vld      (iss_vld),
      .mat_sched_iss_type     (iss_type),
      .mat_sched_iss_data     (iss_data),
      .mat_exu_sched_rdy      (rdy),
      .mat_exu_sched_cfg_done (cfg_done),
      .mat_sched_empty        (empty)
   );

   typedef struct {
      logic [3:0]  t;
      logic [36:0] d;
   } ent_t;

   ent_t mq[$];
   bit   m_cfg_wait;
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc %0d got %0h exp %0h", nm, cyc, act, exp);
      end
   endtask

   // Reference model: compare at negedge, then advance to what the next posedge commits.
   int   e_nv;
   bit   e_stall, e_vld, e_empty;
   always @(negedge cpuclk) begin
      cyc++;
      if (cpurst_b) begin
         e_nv    = int'(v0) + int'(v1) + int'(v2);
         e_stall = flush || (e_nv > DEPTH - mq.size());
         e_vld   = !flush && !m_cfg_wait && (mq.size() > 0);
         e_empty = (mq.size() == 0) && !m_cfg_wait;
         chk("stall", 64'(stall), 64'(e_stall));
         chk("iss_vld", 64'(iss_vld), 64'(e_vld));
         chk("empty", 64'(empty), 64'(e_empty));
         if (e_vld) begin
            chk("iss_type", 64'(iss_type), 64'(mq[0].t));
            chk("iss_data", 64'(iss_data), 64'(mq[0].d));
         end
         if (flush) begin
            mq.delete();
            m_cfg_wait = 0;
         end else begin
            if (e_vld && rdy) begin
               if (mq[0].t == CFG) m_cfg_wait = 1;
               void'(mq.pop_front());
            end else if (m_cfg_wait && cfg_done) begin
               m_cfg_wait = 0;
            end
            if (!e_stall) begin
               if (v0) mq.push_back('{t0, d0});
               if (v1) mq.push_back('{t1, d1});
               if (v2) mq.push_back('{t2, d2});
            end
         end
      end
   end

   task automatic tick();
      @(posedge cpuclk);
      #1;
   endtask

   task automatic clr();
      v0 = 0; v1 = 0; v2 = 0;
      flush = 0; cfg_done = 0;
   endtask

   task automatic slots(input logic a, input logic [3:0] ta, input logic [36:0] da,
                        input logic b, input logic [3:0] tb, input logic [36:0] db,
                        input logic c, input logic [3:0] tc, input logic [36:0] dc);
      v0 = a; t0 = ta; d0 = da;
      v1 = b; t1 = tb; d1 = db;
      v2 = c; t2 = tc; d2 = dc;
   endtask

   initial begin
      cpurst_b = 0;
      rdy = 0;
      t0 = 0; t1 = 0; t2 = 0; d0 = 0; d1 = 0; d2 = 0;
      clr();
      m_cfg_wait = 0;
      repeat (3) tick();
      cpurst_b = 1;
      #1;
      chk("rst_vld", 64'(iss_vld), 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_empty", 64'(empty), 64'd1);

      // three slots, types 2,3,4, back-to-back issue
      tick();
      rdy = 1;
      slots(1, 4'h2, 37'h1, 1, 4'h3, 37'h2, 1, 4'h4, 37'h3);
      #1 chk("s1_stall", 64'(stall), 64'd0);
      tick(); clr();
      #1 chk("s1_c1", 64'({iss_vld, iss_type}), 64'h12);
      tick(); #1 chk("s1_c2", 64'({iss_vld, iss_type}), 64'h13);
      tick(); #1 chk("s1_c3", 64'({iss_vld, iss_type}), 64'h14);
      tick(); #1 chk("s1_empty", 64'({iss_vld, empty}), 64'h1);

      // compaction around an invalid slot1
      slots(1, 4'h2, 37'hA, 0, 4'h5, 37'hB, 1, 4'h3, 37'hC);
      tick(); clr();
      #1 chk("s2_a", 64'(iss_data), 64'hA);
      tick(); #1 chk("s2_c", 64'({iss_vld, iss_data}), {27'd0, 1'b1, 37'hC});
      tick();

      // fill to 6 with rdy low, then all-or-none stall, then fill to full
      rdy = 0;
      slots(1, 4'h2, 37'h10, 1, 4'h2, 37'h11, 1, 4'h2, 37'h12);
      tick();
      slots(1, 4'h2, 37'h13, 1, 4'h2, 37'h14, 1, 4'h2, 37'h15);
      tick();
      slots(1, 4'h2, 37'h16, 1, 4'h2, 37'h17, 1, 4'h2, 37'h18);
      #1 chk("s3_stall3", 64'(stall), 64'd1);
      tick();
      slots(1, 4'h2, 37'h16, 0, 4'h2, 37'h17, 1, 4'h2, 37'h18);
      #1 chk("s3_acc2", 64'(stall), 64'd0);
      tick();
      slots(0, 4'h2, 37'h0, 1, 4'h2, 37'h19, 0, 4'h2, 37'h0);
      #1 chk("s3_full", 64'(stall), 64'd1);
      tick(); clr();
      rdy = 1;
      repeat (8) tick();
      #1 chk("s3_drained", 64'(empty), 64'd1);

      // config serialization with a 5-cycle wait
      slots(1, CFG, 37'h11, 1, 4'h2, 37'h22, 0, 4'h0, 37'h0);
      tick(); clr();
      #1 chk("s4_cfg", 64'({iss_vld, iss_type}), 64'h11);
      for (int i = 0; i < 5; i++) begin
         tick();
         #1 chk("s4_wait", 64'({iss_vld, empty}), 64'h0);
         if (i == 4) cfg_done = 1;
      end
      tick(); cfg_done = 0;
      #1 chk("s4_after", 64'({iss_vld, iss_type}), 64'h12);
      tick();

      // flush in CFG_WAIT together with cfg_done and three valids
      slots(1, CFG, 37'h31, 1, 4'h2, 37'h32, 1, 4'h2, 37'h33);
      tick();
      slots(1, 4'h3, 37'h34, 1, 4'h3, 37'h35, 0, 4'h0, 37'h0);
      #1 chk("s5_cfg", 64'(iss_type), 64'h1);
      tick();
      slots(1, 4'h2, 37'h36, 1, 4'h2, 37'h37, 1, 4'h2, 37'h38);
      flush = 1; cfg_done = 1;
      #1 chk("s5_flush", 64'({stall, iss_vld}), 64'h2);
      tick(); clr();
      #1 chk("s5_post", 64'({empty, iss_vld}), 64'h2);
      tick();

      // randomized traffic
      for (int n = 0; n < 2000; n++) begin
         v0 = 1'($urandom_range(0, 1));
         v1 = 1'($urandom_range(0, 1));
         v2 = 1'($urandom_range(0, 1));
         t0 = ($urandom_range(0, 7) == 0) ? CFG : 4'($urandom_range(2, 15));
         t1 = ($urandom_range(0, 7) == 0) ? CFG : 4'($urandom_range(2, 15));
         t2 = ($urandom_range(0, 7) == 0) ? CFG : 4'($urandom_range(2, 15));
         d0 = 37'({$urandom, $urandom});
         d1 = 37'({$urandom, $urandom});
         d2 = 37'({$urandom, $urandom});
         rdy = ((n / 64) % 3 == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
         cfg_done = ($urandom_range(0, 5) == 0);
         flush = ($urandom_range(0, 59) == 0);
         tick();
      end
      clr();
      tick();

      // asynchronous reset mid-stream
      rdy = 0;
      slots(1, 4'h2, 37'h41, 1, 4'h3, 37'h42, 1, 4'h4, 37'h43);
      tick(); clr();
      #2 cpurst_b = 0;
      mq.delete();
      m_cfg_wait = 0;
      #1 chk("arst_vld", 64'(iss_vld), 64'd0);
      chk("arst_empty", 64'(empty), 64'd1);
      tick(); tick();
      #5 cpurst_b = 1;
      tick();
      rdy = 1;
      slots(1, 4'h3, 37'h55, 0, 4'h0, 37'h0, 0, 4'h0, 37'h0);
      tick(); clr();
      #1 chk("arst_fresh", 64'({iss_vld, iss_type, iss_data}), {22'd0, 1'b1, 4'h3, 37'h55});
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
